ram36_bit_serializer: RTL and testbench

Reads a contiguous run of 36-bit words (32 data + 4 parity) from the wide 512×36 port of a dual-port block RAM and emits them as a gapless serial bitstream with a valid/ready handshake. It sits directly downstream of the RAM's 36-bit read port. It drives that port's address and enable and consumes its data and parity outputs, hiding the RAM's one-cycle read latency behind a prefetch register.

---
 rtl/ram36_bit_serializer.sv | 143 ++++++++++++++
 tb/tb_ram36_bit_serializer.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ram36_bit_serializer.sv
// rtl/ram36_bit_serializer.sv - streams 36-bit block RAM words (parity first) as a gapless MSB-first bitstream
module ram36_bit_serializer #(
    parameter int ADDR_W = 9,
    parameter int LEN_W  = 10
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic              START,
    input  logic [ADDR_W-1:0] BASE_ADDR,
    input  logic [LEN_W-1:0]  NUM_WORDS,
    output logic              RAM_EN,
    output logic [ADDR_W-1:0] RAM_ADDR,
    input  logic [31:0]       RAM_DO,
    input  logic [3:0]        RAM_DOP,
    output logic              BIT_OUT,
    output logic              BIT_VALID,
    input  logic              BIT_READY,
    output logic              BUSY,
    output logic              DONE
);
    typedef enum logic [1:0] {IDLE, RUN, FINISH} state_t;
    localparam logic [LEN_W-1:0] MAX_WORDS = LEN_W'(1 << ADDR_W);

    state_t            state, state_nxt;
    logic [35:0]       sr, hr;
    logic [5:0]        sr_cnt;
    logic              hr_full;
    logic              rd_flight;
    logic              ram_vld;
    logic [ADDR_W-1:0] fetch_addr;
    logic [LEN_W-1:0]  fetch_rem;
    logic [LEN_W-1:0]  send_rem;
    logic [LEN_W-1:0]  num_clamped;

    logic start_ok, accept, sr_last, hr_to_sr, hr_free, capture, issue;

    assign num_clamped = (NUM_WORDS > MAX_WORDS) ? MAX_WORDS : NUM_WORDS;
    assign start_ok    = (state == IDLE) && START;
    assign BIT_VALID   = (sr_cnt != 6'd0);
    assign BIT_OUT     = sr[35];
    assign accept      = BIT_VALID && BIT_READY;
    assign sr_last     = (sr_cnt == 6'd1) && accept;
    assign hr_to_sr    = hr_full && ((sr_cnt == 6'd0) || sr_last);
    assign hr_free     = !hr_full || hr_to_sr;
    // The RAM output register holds its data while RAM_EN is low, so a returned
    // word may wait there until HR frees up; capture and re-issue share one edge.
    assign capture     = rd_flight && ram_vld && hr_free;
    assign issue       = (state == RUN) && (fetch_rem != '0) && (!rd_flight || capture) && hr_free;

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (START) state_nxt = RUN;
            RUN:     if ((send_rem == '0) && ((sr_cnt == 6'd0) || sr_last)) state_nxt = FINISH;
            FINISH:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        BUSY = 1'b0;
        DONE = 1'b0;
        case (state)
            RUN:     BUSY = 1'b1;
            FINISH:  DONE = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            RAM_EN     <= 1'b0;
            RAM_ADDR   <= '0;
            fetch_addr <= '0;
            fetch_rem  <= '0;
            send_rem   <= '0;
            rd_flight  <= 1'b0;
            ram_vld    <= 1'b0;
            hr         <= '0;
            hr_full    <= 1'b0;
            sr         <= '0;
            sr_cnt     <= 6'd0;
        end else begin
            if (start_ok) begin
                send_rem <= num_clamped;
                if (num_clamped != '0) begin
                    RAM_EN     <= 1'b1;
                    RAM_ADDR   <= BASE_ADDR;
                    fetch_addr <= BASE_ADDR + ADDR_W'(1);
                    fetch_rem  <= num_clamped - LEN_W'(1);
                    rd_flight  <= 1'b1;
                end else begin
                    RAM_EN    <= 1'b0;
                    fetch_rem <= '0;
                end
            end else begin
                RAM_EN <= issue;
                if (issue) begin
                    RAM_ADDR   <= fetch_addr;
                    fetch_addr <= fetch_addr + ADDR_W'(1);
                    fetch_rem  <= fetch_rem - LEN_W'(1);
                end
                if (issue) begin
                    rd_flight <= 1'b1;
                end else if (capture) begin
                    rd_flight <= 1'b0;
                end
                if (hr_to_sr) begin
                    send_rem <= send_rem - LEN_W'(1);
                end
            end

            if (RAM_EN) begin
                ram_vld <= 1'b1;
            end else if (capture) begin
                ram_vld <= 1'b0;
            end

            if (capture) begin
                hr      <= {RAM_DOP, RAM_DO};
                hr_full <= 1'b1;
            end else if (hr_to_sr) begin
                hr_full <= 1'b0;
            end

            if (hr_to_sr) begin
                sr     <= hr;
                sr_cnt <= 6'd36;
            end else if (accept) begin
                sr     <= {sr[34:0], 1'b0};
                sr_cnt <= sr_cnt - 6'd1;
            end
        end
    end
endmodule

// File: tb/tb_ram36_bit_serializer.sv
// tb/tb_ram36_bit_serializer.sv - scoreboard bench for ram36_bit_serializer
module tb_ram36_bit_serializer;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [8:0]  base_addr;
    logic [9:0]  num_words;
    logic        ram_en;
    logic [8:0]  ram_addr;
    logic [31:0] ram_do = '0;
    logic [3:0]  ram_dop = '0;
    logic        bit_out, bit_valid, bit_ready, busy, done;

    logic [35:0] mem [0:511];
    logic        exp_bits [$];
    logic [8:0]  exp_addr [$];
    int checks = 0, failures = 0;
    int ncyc = 0, en_count = 0, acc_count = 0, done_count = 0;
    int acc_since_done = 0, first_acc = 0, last_acc = 0;
    logic prev_en = 1'b0, stall_pend = 1'b0, stall_bit = 1'b0;
    int ready_mode = 0;

    always #5 clk = ~clk;

    ram36_bit_serializer dut (
        .CLK(clk), .RST_N(rst_n), .START(start), .BASE_ADDR(base_addr), .NUM_WORDS(num_words),
        .RAM_EN(ram_en), .RAM_ADDR(ram_addr), .RAM_DO(ram_do), .RAM_DOP(ram_dop),
        .BIT_OUT(bit_out), .BIT_VALID(bit_valid), .BIT_READY(bit_ready), .BUSY(busy), .DONE(done)
    );

    // Registered-output block RAM: output holds while the enable is low.
    always @(posedge clk) begin
        if (ram_en) begin
            ram_dop <= mem[ram_addr][35:32];
            ram_do  <= mem[ram_addr][31:0];
        end
    end

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic push_word(input logic [35:0] w);
        for (int b = 35; b >= 0; b--) exp_bits.push_back(w[b]);
    endtask

    task automatic do_start(input logic [8:0] b, input logic [9:0] n);
        @(posedge clk); #1;
        start = 1'b1; base_addr = b; num_words = n;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget, input string name);
        int k;
        for (k = 0; k < budget; k++) begin
            @(posedge clk); #1;
            if (done) break;
        end
        checks++;
        if (k == budget) begin
            failures++;
            $display("FAIL %s_timeout: DONE not seen within %0d cycles", name, budget);
        end
    endtask

    always @(negedge clk) begin
        ncyc++;
        if (!rst_n) begin
            prev_en = 1'b0; stall_pend = 1'b0; acc_since_done = 0;
        end else begin
            if (stall_pend) begin
                chk("stall_valid", 64'(bit_valid), 64'(1'b1));
                chk("stall_bit", 64'(bit_out), 64'(stall_bit));
            end
            stall_pend = bit_valid && !bit_ready;
            stall_bit  = bit_out;
            if (ram_en) begin
                en_count++;
                chk("ram_en_one_in_flight", 64'(prev_en), 64'(1'b0));
                if (exp_addr.size() == 0) begin
                    checks++; failures++;
                    $display("FAIL ram_addr_unexpected: got read of %0d expected no read", ram_addr);
                end else begin
                    chk("ram_addr", 64'(ram_addr), 64'(exp_addr.pop_front()));
                end
            end
            prev_en = ram_en;
            if (bit_valid && bit_ready) begin
                acc_count++;
                if (acc_since_done == 0) first_acc = ncyc;
                last_acc = ncyc;
                acc_since_done++;
                if (exp_bits.size() == 0) begin
                    checks++; failures++;
                    $display("FAIL bit_unexpected: got bit %0d expected none", bit_out);
                end else begin
                    chk("bit", 64'(bit_out), 64'(exp_bits.pop_front()));
                end
            end
            if (done) begin
                done_count++;
                chk("done_busy_low", 64'(busy), 64'(1'b0));
                if (acc_since_done != 0) chk("done_after_last_bit", 64'(ncyc), 64'(last_acc + 1));
                acc_since_done = 0;
            end
        end
    end

    initial begin
        bit_ready = 1'b1;
        forever begin
            @(posedge clk); #1;
            bit_ready = (ready_mode == 0) ? 1'b1 : ($urandom_range(0, 99) < 30);
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int en0, d0, a0, k;
        for (int i = 0; i < 512; i++) mem[i] = '0;
        mem[0]   = 36'h9_0000_0001;
        mem[1]   = 36'hA_DEAD_BEEF;
        mem[2]   = 36'h5_1234_5678;
        mem[3]   = 36'h0_FFFF_0000;
        mem[4]   = 36'hF_0F0F_F0F0;
        mem[10]  = 36'h6_CAFE_F00D;
        mem[11]  = 36'hC_0123_4567;
        mem[12]  = 36'h1_89AB_CDEF;
        mem[20]  = 36'h8_AAAA_5555;
        mem[21]  = 36'h7_0000_FFFF;
        mem[22]  = 36'h2_F00F_0FF0;
        mem[511] = 36'h3_8000_0003;
        rst_n = 1'b0; start = 1'b0; base_addr = '0; num_words = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_ram_en", 64'(ram_en), 64'(1'b0));
        chk("reset_ram_addr", 64'(ram_addr), 64'(9'd0));
        chk("reset_bit_out", 64'(bit_out), 64'(1'b0));
        chk("reset_bit_valid", 64'(bit_valid), 64'(1'b0));
        chk("reset_busy", 64'(busy), 64'(1'b0));
        chk("reset_done", 64'(done), 64'(1'b0));
        rst_n = 1'b1;

        // Single word, then START during FINISH must be ignored
        push_word(36'h9_0000_0001); exp_addr.push_back(9'd0);
        en0 = en_count; d0 = done_count;
        do_start(9'd0, 10'd1);
        chk("launch_busy", 64'(busy), 64'(1'b1));
        chk("launch_ram_en", 64'(ram_en), 64'(1'b1));
        chk("launch_ram_addr", 64'(ram_addr), 64'(9'd0));
        for (k = 1; k <= 8; k++) begin
            @(posedge clk); #1;
            if (bit_valid) break;
        end
        chk("first_valid_edges", 64'(k), 64'(3));
        wait_done(100, "single");
        start = 1'b1; base_addr = 9'd5; num_words = 10'd2;
        @(posedge clk); #1;
        start = 1'b0;
        chk("finish_start_busy", 64'(busy), 64'(1'b0));
        chk("finish_start_ram_en", 64'(ram_en), 64'(1'b0));
        chk("single_en_pulses", 64'(en_count - en0), 64'(1));
        chk("single_done_pulses", 64'(done_count - d0), 64'(1));
        chk("single_bits_left", 64'(exp_bits.size()), 64'(0));

        // Streaming four words, with an ignored START mid-transfer
        for (int i = 1; i <= 4; i++) begin push_word(mem[i]); exp_addr.push_back(9'(i)); end
        en0 = en_count; d0 = done_count; a0 = acc_count;
        do_start(9'd1, 10'd4);
        repeat (40) @(posedge clk);
        #1; start = 1'b1; base_addr = 9'd300; num_words = 10'd7;
        @(posedge clk); #1; start = 1'b0;
        wait_done(400, "stream");
        @(posedge clk); #1;
        chk("stream_en_pulses", 64'(en_count - en0), 64'(4));
        chk("stream_done_pulses", 64'(done_count - d0), 64'(1));
        chk("stream_bits", 64'(acc_count - a0), 64'(144));
        chk("stream_gapless_span", 64'(last_acc - first_acc + 1), 64'(144));
        chk("stream_bits_left", 64'(exp_bits.size()), 64'(0));

        // Address wrap 511 -> 0
        push_word(36'h3_8000_0003); exp_addr.push_back(9'd511);
        push_word(36'h9_0000_0001); exp_addr.push_back(9'd0);
        en0 = en_count;
        do_start(9'd511, 10'd2);
        wait_done(300, "wrap");
        @(posedge clk); #1;
        chk("wrap_en_pulses", 64'(en_count - en0), 64'(2));
        chk("wrap_bits_left", 64'(exp_bits.size()), 64'(0));

        // Backpressure at roughly 30% ready
        for (int i = 10; i <= 12; i++) begin push_word(mem[i]); exp_addr.push_back(9'(i)); end
        en0 = en_count; a0 = acc_count;
        ready_mode = 1;
        do_start(9'd10, 10'd3);
        wait_done(3000, "backpressure");
        ready_mode = 0;
        @(posedge clk); #1;
        chk("bp_en_pulses", 64'(en_count - en0), 64'(3));
        chk("bp_bits", 64'(acc_count - a0), 64'(108));
        chk("bp_bits_left", 64'(exp_bits.size()), 64'(0));

        // Zero length
        en0 = en_count;
        do_start(9'd7, 10'd0);
        chk("zero_busy", 64'(busy), 64'(1'b1));
        @(posedge clk); #1;
        chk("zero_done", 64'(done), 64'(1'b1));
        chk("zero_busy_low", 64'(busy), 64'(1'b0));
        @(posedge clk); #1;
        chk("zero_done_single", 64'(done), 64'(1'b0));
        chk("zero_no_ram_en", 64'(en_count - en0), 64'(0));

        // Reset after about 50 bits of a 3-word transfer
        for (int i = 20; i <= 22; i++) begin push_word(mem[i]); exp_addr.push_back(9'(i)); end
        a0 = acc_count;
        do_start(9'd20, 10'd3);
        for (k = 0; k < 300; k++) begin
            @(posedge clk); #1;
            if (acc_count - a0 >= 50) break;
        end
        chk("reset_reach_50_bits", 64'(k < 300), 64'(1'b1));
        rst_n = 1'b0;
        @(posedge clk); #1;
        chk("midrst_ram_en", 64'(ram_en), 64'(1'b0));
        chk("midrst_ram_addr", 64'(ram_addr), 64'(9'd0));
        chk("midrst_bit_out", 64'(bit_out), 64'(1'b0));
        chk("midrst_bit_valid", 64'(bit_valid), 64'(1'b0));
        chk("midrst_busy", 64'(busy), 64'(1'b0));
        chk("midrst_done", 64'(done), 64'(1'b0));
        rst_n = 1'b1;
        exp_bits.delete(); exp_addr.delete();
        d0 = done_count;
        repeat (60) @(posedge clk);
        #1;
        chk("midrst_no_done", 64'(done_count - d0), 64'(0));
        chk("midrst_idle", 64'(busy), 64'(1'b0));
        push_word(36'hA_DEAD_BEEF); exp_addr.push_back(9'd1);
        en0 = en_count; d0 = done_count;
        do_start(9'd1, 10'd1);
        wait_done(200, "after_reset");
        @(posedge clk); #1;
        chk("after_reset_en", 64'(en_count - en0), 64'(1));
        chk("after_reset_done", 64'(done_count - d0), 64'(1));
        chk("after_reset_bits_left", 64'(exp_bits.size()), 64'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
